cnn_tile_sched: RTL and testbench

//  Layer-level sequencer for CNNBuffer: splits an input feature map (in_w x in_h x ch) into row bands of <=BUFFER_DEPTH rows.

---
 rtl/cnn_tile_sched_pkg.sv | 49 ++++
 rtl/cnn_tile_addr_gen.sv | 75 +++++++
 rtl/cnn_tile_sched.sv | 109 ++++++++++
 tb/tb_cnn_tile_sched.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/cnn_tile_sched_pkg.sv
// Shared constants, layer descriptor type and small arithmetic helpers
// for the CNN tile scheduler and its address generator.
package cnn_tile_sched_pkg;

  localparam int BUFFER_WIDTH = 32;
  localparam int BUFFER_DEPTH = 8;
  localparam int KERNEL_SIZE  = 5;
  localparam int KERNEL_WIDTH = $clog2(KERNEL_SIZE) + 1;
  localparam int DIM_W        = 12;
  localparam int CH_W         = 10;
  localparam int ADDR_W       = 32;
  localparam int DEPTH_W      = $clog2(BUFFER_DEPTH);
  localparam int BWID_W       = $clog2(BUFFER_WIDTH);
  localparam int INW_W        = BWID_W + 1;
  localparam int PROD_W       = DIM_W + INW_W;

  typedef struct packed {
    logic [ADDR_W-1:0]       base;
    logic [DIM_W-1:0]        in_w;
    logic [DIM_W-1:0]        in_h;
    logic [CH_W-1:0]         ch;
    logic [KERNEL_WIDTH-1:0] k_w;
    logic [KERNEL_WIDTH-1:0] k_h;
  } layer_cfg_t;

  function automatic logic [DIM_W-1:0] kext(input logic [KERNEL_WIDTH-1:0] k);
    return {{(DIM_W-KERNEL_WIDTH){1'b0}}, k};
  endfunction

  function automatic logic cfg_invalid(input layer_cfg_t c);
    return (c.k_w == '0) || (c.k_h == '0) ||
           (c.k_w > KERNEL_WIDTH'(KERNEL_SIZE)) ||
           (c.k_h > KERNEL_WIDTH'(KERNEL_SIZE)) ||
           (c.in_w == '0) || (c.in_w > DIM_W'(BUFFER_WIDTH)) ||
           (c.in_w < kext(c.k_w)) || (c.in_h < kext(c.k_h)) ||
           (c.ch == '0);
  endfunction

  // Row length never exceeds BUFFER_WIDTH once validated, so a narrow operand suffices.
  function automatic logic [PROD_W-1:0] mul_inw(input logic [DIM_W-1:0] a,
                                                input logic [INW_W-1:0] b);
    return {{INW_W{1'b0}}, a} * {{DIM_W{1'b0}}, b};
  endfunction

  function automatic logic [ADDR_W-1:0] words_to_bytes(input logic [PROD_W-1:0] w);
    return {{(ADDR_W-PROD_W-2){1'b0}}, w, 2'b00};
  endfunction

endpackage

// File: rtl/cnn_tile_addr_gen.sv
// Band/channel walker: holds band start, channel index, row count and the
// byte address of the current tile, stepped by init/next_ch/next_band.
module cnn_tile_addr_gen
  import cnn_tile_sched_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_init,
  input  logic                    i_next_ch,
  input  logic                    i_next_band,
  input  logic [ADDR_W-1:0]       i_base,
  input  logic [DIM_W-1:0]        i_in_h,
  input  logic [INW_W-1:0]        i_in_w,
  input  logic [CH_W-1:0]         i_ch,
  input  logic [KERNEL_WIDTH-1:0] i_k_h,
  output logic [ADDR_W-1:0]       o_tile_base,
  output logic [DEPTH_W-1:0]      o_depth,
  output logic                    o_last_ch,
  output logic                    o_last_band
);

  logic [DIM_W-1:0]   r_band_start, r_step_rows;
  logic [DIM_W-1:0]   w_step_rows, w_bs_next, w_rem;
  logic [CH_W-1:0]    r_ch_idx;
  logic [ADDR_W-1:0]  r_band_base, r_tile_base, r_plane_bytes, r_step_bytes;
  logic [DEPTH_W-1:0] r_depth;
  logic               r_last_band, w_last;

  // Bands only advance from a full band, so the row step is fixed per layer.
  assign w_step_rows = DIM_W'(BUFFER_DEPTH + 1) - kext(i_k_h);
  assign w_bs_next   = i_init ? '0 : r_band_start + r_step_rows;
  assign w_rem       = i_in_h - w_bs_next;
  assign w_last      = (w_rem <= DIM_W'(BUFFER_DEPTH));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_band_start  <= '0;
      r_step_rows   <= '0;
      r_ch_idx      <= '0;
      r_band_base   <= '0;
      r_tile_base   <= '0;
      r_plane_bytes <= '0;
      r_step_bytes  <= '0;
      r_depth       <= '0;
      r_last_band   <= 1'b0;
    end else if (i_init) begin
      r_plane_bytes <= words_to_bytes(mul_inw(i_in_h, i_in_w));
      r_step_bytes  <= words_to_bytes(mul_inw(w_step_rows, i_in_w));
      r_step_rows   <= w_step_rows;
      r_band_start  <= w_bs_next;
      r_ch_idx      <= '0;
      r_band_base   <= i_base;
      r_tile_base   <= i_base;
      r_depth       <= w_last ? (w_rem[DEPTH_W-1:0] - DEPTH_W'(1)) : DEPTH_W'(BUFFER_DEPTH - 1);
      r_last_band   <= w_last;
    end else if (i_next_band) begin
      r_band_start  <= w_bs_next;
      r_ch_idx      <= '0;
      r_band_base   <= r_band_base + r_step_bytes;
      r_tile_base   <= r_band_base + r_step_bytes;
      r_depth       <= w_last ? (w_rem[DEPTH_W-1:0] - DEPTH_W'(1)) : DEPTH_W'(BUFFER_DEPTH - 1);
      r_last_band   <= w_last;
    end else if (i_next_ch) begin
      r_ch_idx      <= r_ch_idx + CH_W'(1);
      r_tile_base   <= r_tile_base + r_plane_bytes;
    end
  end

  assign o_tile_base = r_tile_base;
  assign o_depth     = r_depth;
  assign o_last_ch   = (r_ch_idx == i_ch - CH_W'(1));
  assign o_last_band = r_last_band;

endmodule

// File: rtl/cnn_tile_sched.sv
// Layer sequencer for CNNBuffer: validates a descriptor, then walks
// (band, channel) tiles issuing req / req_final around each buffer pass.
module cnn_tile_sched
  import cnn_tile_sched_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [DIM_W-1:0]        cfg_in_w,
  input  logic [DIM_W-1:0]        cfg_in_h,
  input  logic [CH_W-1:0]         cfg_ch,
  input  logic [KERNEL_WIDTH-1:0] cfg_k_w,
  input  logic [KERNEL_WIDTH-1:0] cfg_k_h,
  input  logic [ADDR_W-1:0]       cfg_base,
  output logic                    buf_req,
  output logic                    buf_req_final,
  output logic [KERNEL_WIDTH-1:0] buf_kernel_w,
  output logic [KERNEL_WIDTH-1:0] buf_kernel_h,
  output logic [DEPTH_W-1:0]      buf_depth,
  output logic [BWID_W-1:0]       buf_width,
  output logic [ADDR_W-1:0]       tile_base,
  input  logic                    buf_window_finish,
  input  logic                    pe_drain_done,
  output logic                    busy,
  output logic                    done,
  output logic                    cfg_err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CHECK  = 3'd1;
  localparam logic [2:0] S_LAUNCH = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;
  localparam logic [2:0] S_FINAL  = 3'd5;
  localparam logic [2:0] S_NEXT   = 3'd6;
  localparam logic [2:0] S_DONE   = 3'd7;

  logic [2:0]        r_state, w_state_next;
  layer_cfg_t        r_cfg;
  logic [BWID_W-1:0] r_buf_width;
  logic              w_accept, w_reject, w_last_ch, w_last_band;
  logic              w_init, w_next_ch, w_next_band;

  assign w_accept    = cfg_valid && (r_state == S_IDLE);
  assign w_reject    = cfg_invalid(r_cfg);
  assign w_init      = (r_state == S_CHECK);
  assign w_next_ch   = (r_state == S_NEXT) && !w_last_ch;
  assign w_next_band = (r_state == S_NEXT) && w_last_ch && !w_last_band;

  // NOTE: the default assignment up front keeps this block free of inferred latches.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_next = S_CHECK;
      S_CHECK:  w_state_next = w_reject ? S_IDLE : S_LAUNCH;
      S_LAUNCH: w_state_next = S_RUN;
      S_RUN:    if (buf_window_finish) w_state_next = S_DRAIN;
      S_DRAIN:  if (pe_drain_done) w_state_next = S_FINAL;
      S_FINAL:  w_state_next = S_NEXT;
      S_NEXT:   w_state_next = (w_last_ch && w_last_band) ? S_DONE : S_LAUNCH;
      S_DONE:   w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cfg       <= '0;
      r_buf_width <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_cfg       <= '{base: cfg_base, in_w: cfg_in_w, in_h: cfg_in_h,
                         ch: cfg_ch, k_w: cfg_k_w, k_h: cfg_k_h};
        r_buf_width <= cfg_in_w[BWID_W-1:0] - BWID_W'(1);
      end
    end
  end

  cnn_tile_addr_gen u_addr_gen (
    .clk         (clk),
    .rst         (rst),
    .i_init      (w_init),
    .i_next_ch   (w_next_ch),
    .i_next_band (w_next_band),
    .i_base      (r_cfg.base),
    .i_in_h      (r_cfg.in_h),
    .i_in_w      (r_cfg.in_w[INW_W-1:0]),
    .i_ch        (r_cfg.ch),
    .i_k_h       (r_cfg.k_h),
    .o_tile_base (tile_base),
    .o_depth     (buf_depth),
    .o_last_ch   (w_last_ch),
    .o_last_band (w_last_band)
  );

  assign cfg_ready     = (r_state == S_IDLE);
  assign busy          = (r_state != S_IDLE);
  assign buf_req       = (r_state == S_LAUNCH);
  assign buf_req_final = (r_state == S_FINAL);
  assign done          = (r_state == S_DONE);
  assign cfg_err       = (r_state == S_CHECK) && w_reject;
  assign buf_kernel_w  = r_cfg.k_w;
  assign buf_kernel_h  = r_cfg.k_h;
  assign buf_width     = r_buf_width;

endmodule

// File: tb/tb_cnn_tile_sched.sv
// Directed bench for cnn_tile_sched: table of layer descriptors with
// hand-computed tile sequences, plus reset-mid-run and back-to-back cases.
module tb_cnn_tile_sched;
  import cnn_tile_sched_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    cfg_valid;
  logic                    cfg_ready;
  logic [DIM_W-1:0]        cfg_in_w, cfg_in_h;
  logic [CH_W-1:0]         cfg_ch;
  logic [KERNEL_WIDTH-1:0] cfg_k_w, cfg_k_h;
  logic [ADDR_W-1:0]       cfg_base;
  logic                    buf_req, buf_req_final;
  logic [KERNEL_WIDTH-1:0] buf_kernel_w, buf_kernel_h;
  logic [DEPTH_W-1:0]      buf_depth;
  logic [BWID_W-1:0]       buf_width;
  logic [ADDR_W-1:0]       tile_base;
  logic                    buf_window_finish, pe_drain_done;
  logic                    busy, done, cfg_err;

  always #5 clk = ~clk;

  cnn_tile_sched dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_in_w(cfg_in_w), .cfg_in_h(cfg_in_h), .cfg_ch(cfg_ch),
    .cfg_k_w(cfg_k_w), .cfg_k_h(cfg_k_h), .cfg_base(cfg_base),
    .buf_req(buf_req), .buf_req_final(buf_req_final),
    .buf_kernel_w(buf_kernel_w), .buf_kernel_h(buf_kernel_h),
    .buf_depth(buf_depth), .buf_width(buf_width), .tile_base(tile_base),
    .buf_window_finish(buf_window_finish), .pe_drain_done(pe_drain_done),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  typedef struct packed {
    logic [11:0]      in_w;
    logic [11:0]      in_h;
    logic [9:0]       ch;
    logic [3:0]       k_w;
    logic [3:0]       k_h;
    logic [31:0]      base;
    logic [3:0]       tiles;   // 0 means the descriptor must be rejected
    logic [3:0][31:0] bases;
    logic [3:0][2:0]  depths;
    logic             hold;    // pe_drain_done held high for the whole layer
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic vec_t mk(input int w, input int h, input int ch, input int kw,
                              input int kh, input logic [31:0] base, input int tiles,
                              input logic [3:0][31:0] b, input logic [3:0][2:0] d,
                              input bit hold);
    vec_t v;
    v.in_w = 12'(w); v.in_h = 12'(h); v.ch = 10'(ch);
    v.k_w = 4'(kw); v.k_h = 4'(kh); v.base = base;
    v.tiles = 4'(tiles); v.bases = b; v.depths = d; v.hold = hold;
    return v;
  endfunction

  task automatic load_cfg(input vec_t v);
    cfg_in_w = v.in_w; cfg_in_h = v.in_h; cfg_ch = v.ch;
    cfg_k_w = v.k_w; cfg_k_h = v.k_h; cfg_base = v.base;
    cfg_valid = 1'b1;
  endtask

  // Plays CNNBuffer/PE: window_finish 2 cycles after req, an early drain pulse
  // in RUN (must be ignored) and the real drain pulse 4 cycles after req.
  task automatic run_layer(input vec_t v, input int layers, input bit keep_valid);
    int c, cs, idx, n_req, n_final, n_done, n_err, req_c, fin_c, bad_ready;
    bit fin;
    bit exp_err;
    exp_err = (v.tiles == 0);
    n_req = 0; n_final = 0; n_done = 0; n_err = 0; bad_ready = 0;
    req_c = -100; fin_c = -100; fin = 1'b0; c = 0;
    @(negedge clk);
    check("ready_before_cfg", cfg_ready, 1);
    load_cfg(v);
    while (!fin && c < 400) begin
      @(negedge clk);
      c++;
      if (!keep_valid) cfg_valid = 1'b0;
      if (busy == cfg_ready) bad_ready++;
      if (buf_req) begin
        idx = (v.tiles != 0) ? (n_req % v.tiles) : 0;
        check("tile_base", tile_base, v.bases[idx]);
        check("buf_depth", buf_depth, v.depths[idx]);
        check("buf_width", buf_width, v.in_w - 1);
        check("buf_kernel", {buf_kernel_w, buf_kernel_h}, {v.k_w, v.k_h});
        n_req++;
        req_c = c;
      end
      if (buf_req_final) begin
        check("req_final_gap", c - req_c, v.hold ? 4 : 5);
        n_final++;
        fin_c = c;
      end
      if (done) begin
        check("done_gap", c - fin_c, 2);
        n_done++;
        if (n_done == layers) fin = 1'b1;
      end
      if (cfg_err) begin
        n_err++;
        fin = 1'b1;
      end
      cs = c - req_c;
      buf_window_finish = (cs == 2);
      pe_drain_done     = v.hold || (cs == 1) || (cs == 4);
    end
    cfg_valid = 1'b0; buf_window_finish = 1'b0; pe_drain_done = 1'b0;
    check("layer_completed", fin, 1);
    check("cfg_err_pulses", n_err, exp_err ? 1 : 0);
    check("req_count", n_req, exp_err ? 0 : v.tiles * layers);
    check("req_final_count", n_final, exp_err ? 0 : v.tiles * layers);
    check("done_count", n_done, exp_err ? 0 : layers);
    check("ready_tracks_idle", bad_ready, 0);
    @(negedge clk);
    check("ready_after", cfg_ready, 1);
    check("busy_after", busy, 0);
  endtask

  task automatic reset_mid_run(input vec_t v);
    int c, n_req, req_c, cs, bad;
    bit hit;
    c = 0; n_req = 0; req_c = -100; hit = 1'b0; bad = 0;
    @(negedge clk);
    load_cfg(v);
    while (!hit && c < 200) begin
      @(negedge clk);
      c++;
      cfg_valid = 1'b0;
      if (buf_req) begin n_req++; req_c = c; end
      cs = c - req_c;
      if (n_req == 2 && cs == 1) hit = 1'b1;
      buf_window_finish = (cs == 2);
      pe_drain_done     = (cs == 4);
    end
    check("reached_tile2_run", hit, 1);
    rst = 1'b1; buf_window_finish = 1'b0; pe_drain_done = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_ready", cfg_ready, 1);
    check("rst_no_req_final", buf_req_final, 0);
    check("rst_no_done", done, 0);
    check("rst_tile_base", tile_base, 0);
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (buf_req || buf_req_final || done || busy) bad++;
    end
    check("quiet_after_rst", bad, 0);
  endtask

  vec_t vecs[12];

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_in_w = '0; cfg_in_h = '0; cfg_ch = '0;
    cfg_k_w = '0; cfg_k_h = '0; cfg_base = '0;
    buf_window_finish = 1'b0; pe_drain_done = 1'b0;

    vecs[0]  = mk(16, 10, 2, 3, 3, 32'h1000, 4,
                  {32'h1400, 32'h1180, 32'h1280, 32'h1000}, {3'd3, 3'd3, 3'd7, 3'd7}, 1'b0);
    vecs[1]  = mk(8, 8, 1, 3, 3, 32'h2000, 1, {96'h0, 32'h2000}, {9'h0, 3'd7}, 1'b1);
    vecs[2]  = mk(33, 8, 1, 3, 3, 32'h0, 0, '0, '0, 1'b0);
    vecs[3]  = mk(16, 8, 1, 0, 3, 32'h0, 0, '0, '0, 1'b0);
    vecs[4]  = mk(32, 12, 1, 5, 5, 32'h4000, 2, {64'h0, 32'h4200, 32'h4000},
                  {6'h0, 3'd7, 3'd7}, 1'b0);
    vecs[5]  = mk(4, 3, 3, 3, 3, 32'hFFFF_FFF0, 3,
                  {32'h0, 32'h50, 32'h20, 32'hFFFF_FFF0}, {3'd0, 3'd2, 3'd2, 3'd2}, 1'b0);
    vecs[6]  = mk(2, 20, 1, 1, 1, 32'h100, 3, {32'h0, 32'h180, 32'h140, 32'h100},
                  {3'd0, 3'd3, 3'd7, 3'd7}, 1'b0);
    vecs[7]  = mk(8, 2, 1, 3, 3, 32'h0, 0, '0, '0, 1'b0);
    vecs[8]  = mk(4, 8, 1, 5, 3, 32'h0, 0, '0, '0, 1'b0);
    vecs[9]  = mk(8, 8, 0, 3, 3, 32'h0, 0, '0, '0, 1'b0);
    vecs[10] = mk(8, 8, 1, 3, 6, 32'h0, 0, '0, '0, 1'b0);
    vecs[11] = mk(8, 8, 1, 1, 5, 32'h3000, 1, {96'h0, 32'h3000}, {9'h0, 3'd7}, 1'b0);

    repeat (3) @(negedge clk);
    check("reset_cfg_ready", cfg_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_pulses", {buf_req, buf_req_final, done, cfg_err}, 0);
    check("reset_tile_base", tile_base, 0);
    check("reset_buf_fields", {buf_depth, buf_width, buf_kernel_w, buf_kernel_h}, 0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) run_layer(vecs[i], 1, 1'b0);

    reset_mid_run(vecs[0]);
    run_layer(vecs[0], 1, 1'b0);
    run_layer(vecs[5], 2, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
